// File: rtl/mem_arbiter.sv
// Two-port cache-to-memory arbiter: serialises icache/dcache line transfers onto one memory port.
// Optional `ARB_ROUND_ROBIN_EN` alternates ties; otherwise the dcache always wins a tie.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imreq,
  input  logic [ADDR_WIDTH-1:0] iad,
  output logic [BUS_WIDTH-1:0]  idt,
  output logic                  acki_n,
  input  logic                  dmreq,
  input  logic                  dmwrite,
  input  logic [ADDR_WIDTH-1:0] dad,
  input  logic [BUS_WIDTH-1:0]  d_wdt,
  output logic [BUS_WIDTH-1:0]  d_rdt,
  output logic                  ackd_n,
  output logic [ADDR_WIDTH-1:0] mad,
  output logic                  mreq,
  output logic                  mwrite,
  output logic [BUS_WIDTH-1:0]  mwdt,
  input  logic [BUS_WIDTH-1:0]  mrdt,
  input  logic                  ackm_n
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t                state, state_nxt;
  logic                  last_d, last_d_nxt;
  logic                  mwrite_nxt;
  logic [ADDR_WIDTH-1:0] mad_nxt;
  logic [BUS_WIDTH-1:0]  mwdt_nxt;
  logic                  pick_d;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, serve the side that did not win the previous grant.
    pick_d = dmreq && (!imreq || !last_d);
`else
    pick_d = dmreq;
`endif
  end

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    mad_nxt    = mad;
    mwrite_nxt = mwrite;
    mwdt_nxt   = mwdt;
    case (state)
      IDLE: begin
        if (dmreq || imreq) begin
          if (pick_d) begin
            state_nxt  = GNT_D;
            last_d_nxt = 1'b1;
            mad_nxt    = dad;
            mwrite_nxt = dmwrite;
            mwdt_nxt   = d_wdt;
          end else begin
            state_nxt  = GNT_I;
            last_d_nxt = 1'b0;
            mad_nxt    = iad;
            mwrite_nxt = 1'b0;
          end
        end
      end
      GNT_I, GNT_D: begin
        if (!ackm_n) begin
          state_nxt  = IDLE;
          mwrite_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
      mreq   <= 1'b0;
      mwrite <= 1'b0;
      mad    <= '0;
      mwdt   <= '0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
      mreq   <= (state_nxt != IDLE);
      mwrite <= mwrite_nxt;
      mad    <= mad_nxt;
      mwdt   <= mwdt_nxt;
    end
  end

  // Memory ack is steered combinationally to whichever side holds the grant.
  assign acki_n = !((state == GNT_I) && !ackm_n);
  assign ackd_n = !((state == GNT_D) && !ackm_n);
  assign idt    = mrdt;
  assign d_rdt  = mrdt;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Downstream of the instruction and data caches; merges their two memory-side request ports onto one shared external memory port.
- Each cache sees a private request/ack handshake: mreq level, ackm_n active-low, 256-bit line data.
- Serialises line fills and write-backs: one outstanding memory transaction at a time; grant is held until the memory acknowledges.

Parameters:
- ADDR_WIDTH, 32, width of cache/memory line addresses
- BUS_WIDTH, 256, width of a cache line transfer

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- imreq  input  1  icache memory request (level, held until acked)
- iad  input  ADDR_WIDTH  icache line address
- idt  output  BUS_WIDTH  line data returned to icache
- acki_n  output  1  icache ack, active-low, one cycle
- dmreq  input  1  dcache memory request (level, held until acked)
- dmwrite  input  1  dcache request is a write-back
- dad  input  ADDR_WIDTH  dcache line address
- d_wdt  input  BUS_WIDTH  dcache write-back line data
- d_rdt  output  BUS_WIDTH  line data returned to dcache
- ackd_n  output  1  dcache ack, active-low, one cycle
- mad  output  ADDR_WIDTH  shared memory address
- mreq  output  1  shared memory request
- mwrite  output  1  shared memory write strobe
- mwdt  output  BUS_WIDTH  shared memory write data
- mrdt  input  BUS_WIDTH  shared memory read data
- ackm_n  input  1  memory ack, active-low, one cycle

Behaviour:
- States: IDLE, GNT_I, GNT_D.
- Reset (rst low, asynchronous):
  - state=IDLE
  - mreq=0, mwrite=0, mad=0, mwdt=0
  - acki_n=1, ackd_n=1
  - last-grant flag = I
- IDLE, arbitration on the clock edge:
  - dmreq=1 wins: go to GNT_D; latch dad, dmwrite, d_wdt into mad, mwrite, mwdt.
  - Otherwise imreq=1: go to GNT_I; latch iad into mad, mwrite=0, mwdt unchanged.
  - Neither: stay in IDLE.
- mreq is registered: it is 1 exactly while in GNT_I or GNT_D. Latency request→mreq = 1 cycle.
- GNT_x holds until ackm_n=0 is sampled:
  - While ackm_n=0, forward the ack combinationally to the granted side only: ack{i|d}_n=0. The other ack stays 1.
  - idt=mrdt and d_rdt=mrdt are driven combinationally at all times; each is valid only while its own ack is low.
  - Next edge: state→IDLE, mreq=0, mwrite=0.
- ackm_n=0 while in IDLE is ignored; no ack is forwarded.
- At least one IDLE cycle separates transactions. A request still pending at ack time is re-arbitrated from IDLE.
- Requester deasserting its request before ack is a protocol error; the arbiter keeps mreq asserted until ack regardless.
- Reset mid-transaction aborts immediately: mreq drops, no ack is issued, and requesters must re-request.
- Latched mad/mwrite/mwdt are stable for the whole grant; input changes after the grant are ignored.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both requests are present in IDLE, grant the side NOT granted last. The last-grant flag updates at each grant; after reset it is I, so the first tie goes to D.
- Undefined: fixed priority, dcache always wins ties (the icache can be starved by continuous dcache traffic).

Test Plan:
- Single icache read: imreq=1, iad=0x0000_1000; memory acks 3 cycles after mreq with mrdt=pattern A → mad=0x1000, mwrite=0; acki_n low 1 cycle with idt=A; ackd_n stays 1; mreq falls next cycle.
- Dcache write-back: dmreq=1, dmwrite=1, dad=0x2000, d_wdt=B → mreq=1, mwrite=1, mad=0x2000, mwdt=B until ack; ackd_n pulses once.
- Simultaneous requests, fixed priority: imreq=dmreq=1 at same edge → dcache served first, then one IDLE cycle, then icache. Order D,I; two ack pulses, none merged.
- Same stimulus with ARB_ROUND_ROBIN_EN, both held continuously for 4 transactions → grant order D,I,D,I.
- Reset mid-grant: assert rst=0 while in GNT_D before ack → mreq=0 asynchronously, no ackd_n pulse. After release with dmreq held, a fresh grant occurs with mad re-latched.
- Stray ackm_n=0 in IDLE → acki_n=ackd_n=1, state stays IDLE.
